// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte-stream requesters, round-robin per message.
// Optional mid-message gap watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_GAP_CLKS = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 tx_dv,
    output logic [7:0]           tx_data,
    input  logic                 tx_active,
    input  logic                 tx_done
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]   LAST_REQ = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_GAP_CLKS < 2) begin : g_param_check
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and MAX_GAP_CLKS at least 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] req_ack_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [IDX_W-1:0]   last_idx_q;
    logic               busy_q;
    logic               tx_dv_q;
    logic [7:0]         tx_data_q;
    logic               is_last_q;

    logic [IDX_W-1:0]   win_idx_s;
    logic               win_found_s;
    int                 cand_s;
    logic               owner_valid_s;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int GAP_W = $clog2(MAX_GAP_CLKS) + 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP_CLKS - 1);
    logic [GAP_W-1:0] gap_q;
    logic             timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign owner_valid_s = req_valid[gidx_q];

    // Round-robin pick: first valid requester scanning upward from last_idx_q+1 with wrap.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = int'(last_idx_q) + k;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && req_valid[cand_s[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Message FSM with all outputs registered; grant is held until the last byte's tx_done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            req_ack_q  <= '0;
            gidx_q     <= '0;
            last_idx_q <= LAST_REQ;
            busy_q     <= 1'b0;
            tx_dv_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            is_last_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            gap_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            req_ack_q <= '0;
            tx_dv_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    // tx_active may be high after reset if uart_tx was mid-frame; wait it out.
                    if (win_found_s && !tx_active) begin
                        grant_q <= ONE_HOT0 << win_idx_s;
                        gidx_q  <= win_idx_s;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                        gap_q   <= '0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (owner_valid_s && !tx_active) begin
                        tx_dv_q           <= 1'b1;
                        tx_data_q         <= req_data[{gidx_q, 3'b000} +: 8];
                        req_ack_q[gidx_q] <= 1'b1;
                        is_last_q         <= req_last[gidx_q];
                        state_q           <= ST_WAIT;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (!owner_valid_s) begin
                        if (gap_q == GAP_LAST) begin
                            timeout_q  <= 1'b1;
                            grant_q    <= '0;
                            busy_q     <= 1'b0;
                            last_idx_q <= gidx_q;
                            state_q    <= ST_IDLE;
                        end else begin
                            gap_q <= gap_q + GAP_W'(1);
                        end
                    end
`endif
                    else begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (is_last_q) begin
                            grant_q    <= '0;
                            busy_q     <= 1'b0;
                            last_idx_q <= gidx_q;
                            state_q    <= ST_IDLE;
                        end else begin
                            state_q <= ST_LOAD;
`ifdef UART_ARB_TIMEOUT_EN
                            gap_q   <= '0;
`endif
                        end
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign req_ack = req_ack_q;
    assign busy    = busy_q;
    assign tx_dv   = tx_dv_q;
    assign tx_data = tx_data_q;

endmodule
